uart_tx_buffer: RTL and testbench

- Transmit-side byte FIFO between the Wishbone UART slave's write path and the serial transmitter driver.
- Absorbs CPU byte writes at bus speed and acks immediately while space remains.
- Drains bytes one at a time into the transmitter using its start/busy handshake.
- Lets software queue a string without polling per byte.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo_mem.sv | 36 +++
 rtl/uart_tx_buffer.sv | 141 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared widths, FIFO depth default and TX FSM state encodings
//               for the UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W           = 8;
    localparam int UART_TXBUF_DEPTH_LOG2 = 4;

    localparam logic [1:0] c_TX_IDLE      = 2'd0;
    localparam logic [1:0] c_TX_START     = 2'd1;
    localparam logic [1:0] c_TX_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_TX_WAIT_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// Module      : uart_fifo_mem
// Description : DEPTH x DATA_W register array, one write port and one
//               asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_TXBUF_DEPTH_LOG2,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
// ============================================================================
// Module      : uart_tx_buffer
// Description : Byte FIFO between the UART bus write path and the serial
//               transmitter start/busy handshake. Optional macro
//               UART_TX_LEVEL_EN adds level_o and almost_full_o outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_TXBUF_DEPTH_LOG2,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_select_i,
    input  logic              bus_we_i,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              bus_ack_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] tx_data_o,
    input  logic              tx_busy_i
`ifdef UART_TX_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                almost_full_o
`endif
);

    localparam int unsigned         c_DEPTH_INT = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH     = c_DEPTH_INT[DEPTH_LOG2:0];

    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [1:0]            r_state;
    logic                  r_ack;
    logic                  r_tx_start;
    logic [DATA_W-1:0]     r_tx_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_W-1:0]     w_rdata;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Holding the strobe through the ack cycle must not enqueue the byte twice.
    assign w_push = bus_select_i & bus_we_i & ~w_full & ~r_ack;
    assign w_pop  = (r_state == c_TX_IDLE) & ~w_empty & ~tx_busy_i;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (bus_data_i),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_ack <= w_push;
        end
    end

    // tx_start is raised on entry to START so it is high for exactly that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_TX_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                c_TX_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_rdata;
                        r_tx_start <= 1'b1;
                        r_state    <= c_TX_START;
                    end
                end
                c_TX_START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= c_TX_WAIT_BUSY;
                end
                c_TX_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        r_state <= c_TX_WAIT_DONE;
                    end
                end
                c_TX_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        r_state <= c_TX_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus_ack_o  = r_ack;
    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign tx_start_o = r_tx_start;
    assign tx_data_o  = r_tx_data;

`ifdef UART_TX_LEVEL_EN
    localparam int unsigned         c_AF_INT   = c_DEPTH_INT - 2;
    localparam logic [DEPTH_LOG2:0] c_AF_LEVEL = c_AF_INT[DEPTH_LOG2:0];

    assign level_o       = r_count;
    assign almost_full_o = (r_count >= c_AF_LEVEL);
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
// ============================================================================
// Module      : tb_uart_tx_buffer
// Description : Self-checking bench for uart_tx_buffer with a queue-based
//               reference model and a behavioural transmitter busy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_select_i;
    logic       bus_we_i;
    logic [7:0] bus_data_i;
    logic       bus_ack_o;
    logic       full_o;
    logic       empty_o;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic       tx_busy_i;
`ifdef UART_TX_LEVEL_EN
    logic [4:0] level_o;
    logic       almost_full_o;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    bit         force_busy = 1'b0;
    bit         auto_en    = 1'b1;
    int         busy_len   = 10;
    int         busy_cnt   = 0;
    bit         pend       = 1'b0;
    bit         prev_start = 1'b0;
    bit         prev_ack   = 1'b0;
    bit         in_frame   = 1'b0;
    bit         seen_busy  = 1'b0;
    logic [7:0] frame_byte = 8'h00;

    always #5 clk = ~clk;

    uart_tx_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .bus_select_i (bus_select_i),
        .bus_we_i     (bus_we_i),
        .bus_data_i   (bus_data_i),
        .bus_ack_o    (bus_ack_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .tx_start_o   (tx_start_o),
        .tx_data_o    (tx_data_o),
        .tx_busy_i    (tx_busy_i)
`ifdef UART_TX_LEVEL_EN
        ,
        .level_o       (level_o),
        .almost_full_o (almost_full_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int model_count();
        return exp_q.size() - got_q.size();
    endfunction

    task automatic check_flags(input string tag);
        check({tag, "_empty"}, 32'(empty_o), 32'(model_count() == 0));
        check({tag, "_full"},  32'(full_o),  32'(model_count() == DEPTH));
`ifdef UART_TX_LEVEL_EN
        check({tag, "_level"}, 32'(level_o), 32'(model_count()));
        check({tag, "_afull"}, 32'(almost_full_o), 32'(model_count() >= DEPTH - 2));
`endif
    endtask

    // Transmitter model: busy rises one cycle after start and lasts busy_len cycles.
    initial begin
        tx_busy_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                in_frame   = 1'b0;
                prev_start = 1'b0;
                prev_ack   = 1'b0;
            end else begin
                if (tx_start_o) begin
                    check("start_gap", 32'(prev_start), 32'd0);
                    got_q.push_back(tx_data_o);
                    frame_byte = tx_data_o;
                    in_frame   = 1'b1;
                    seen_busy  = 1'b0;
                end else if (in_frame) begin
                    check("tx_hold", 32'(tx_data_o), 32'(frame_byte));
                end
                if (bus_ack_o) begin
                    check("ack_pulse", 32'(prev_ack), 32'd0);
                end
                prev_start = tx_start_o;
                prev_ack   = bus_ack_o;
            end
            if (busy_cnt > 0) busy_cnt--;
            if (pend) begin
                busy_cnt = busy_len;
                pend     = 1'b0;
            end
            if (rst && tx_start_o) pend = 1'b1;
            tx_busy_i = force_busy | (auto_en && busy_cnt > 0);
            if (in_frame) begin
                if (tx_busy_i) seen_busy = 1'b1;
                else if (seen_busy) in_frame = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [7:0] b, input int budget);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus_select_i = 1'b1;
        bus_we_i     = 1'b1;
        bus_data_i   = b;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus_ack_o) ok = 1'b1;
        end
        bus_select_i = 1'b0;
        bus_we_i     = 1'b0;
        if (ok) exp_q.push_back(b);
        check("wr_ack", 32'(ok), 32'd1);
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (got_q.size() == exp_q.size() && !tx_busy_i && !in_frame) done = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("drain", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         acks;
        bit         ok;
        logic [7:0] last;

        rst          = 1'b0;
        bus_select_i = 1'b0;
        bus_we_i     = 1'b0;
        bus_data_i   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_empty", 32'(empty_o),    32'd1);
        check("rst_full",  32'(full_o),     32'd0);
        check("rst_ack",   32'(bus_ack_o),  32'd0);
        check("rst_start", 32'(tx_start_o), 32'd0);
        check("rst_data",  32'(tx_data_o),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single byte through an empty FIFO.
        bus_write(8'h41, 20);
        drain(200);
        last = (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx;
        check("single_cnt",   32'(got_q.size()), 32'd1);
        check("single_data",  32'(last),         32'h41);
        check("single_empty", 32'(empty_o),      32'd1);

        // Strobe held through the ack cycle, then read strobes.
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        acks = 0;
        bus_select_i = 1'b1;
        bus_we_i     = 1'b1;
        bus_data_i   = 8'h55;
        repeat (2) begin
            @(negedge clk);
            if (bus_ack_o) acks++;
        end
        bus_select_i = 1'b0;
        bus_we_i     = 1'b0;
        exp_q.push_back(8'h55);
        check("hold_acks", 32'(acks), 32'd1);
        check_flags("hold");
        bus_select_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("read_noack", 32'(bus_ack_o), 32'd0);
        end
        bus_select_i = 1'b0;
        check_flags("read");
        force_busy = 1'b0;
        drain(200);

        // Fill to full, stall the 17th write, release on first pop.
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) bus_write(8'(i), 20);
        check_flags("fill");
        check("fill_full", 32'(full_o), 32'd1);
        bus_select_i = 1'b1;
        bus_we_i     = 1'b1;
        bus_data_i   = 8'h10;
        repeat (6) begin
            @(negedge clk);
            check("stall_ack", 32'(bus_ack_o), 32'd0);
        end
        n  = got_q.size();
        ok = 1'b0;
        force_busy = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus_ack_o) ok = 1'b1;
        end
        bus_select_i = 1'b0;
        bus_we_i     = 1'b0;
        check("stall_release", 32'(ok), 32'd1);
        check("ack_after_pop", 32'(got_q.size() - n), 32'd1);
        if (ok) exp_q.push_back(8'h10);
        drain(2000);

        // Push and pop on the same edge at count 3, across the pointer wrap.
        auto_en    = 1'b0;
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) bus_write(8'h80 + 8'(i), 20);
        for (int k = 0; k < 16; k++) begin
            force_busy = 1'b0;
            @(negedge clk);
            n = got_q.size();
            bus_select_i = 1'b1;
            bus_we_i     = 1'b1;
            bus_data_i   = 8'hC0 + 8'(k);
            @(negedge clk);
            check("sim_ack", 32'(bus_ack_o), 32'd1);
            check("sim_pop", 32'(got_q.size() - n), 32'd1);
            bus_select_i = 1'b0;
            bus_we_i     = 1'b0;
            if (bus_ack_o) exp_q.push_back(8'hC0 + 8'(k));
            force_busy = 1'b1;
            check_flags("sim");
            repeat (2) @(negedge clk);
            force_busy = 1'b0;
            @(negedge clk);
            force_busy = 1'b1;
            @(negedge clk);
        end
        auto_en    = 1'b1;
        force_busy = 1'b0;
        drain(1000);

`ifdef UART_TX_LEVEL_EN
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 13; i++) bus_write(8'h20 + 8'(i), 20);
        check("lvl13_level", 32'(level_o), 32'd13);
        check("lvl13_afull", 32'(almost_full_o), 32'd0);
        bus_write(8'h2D, 20);
        check("lvl14_level", 32'(level_o), 32'd14);
        check("lvl14_afull", 32'(almost_full_o), 32'd1);
        force_busy = 1'b0;
        drain(1000);
`endif

        // Randomized writes, read strobes and transmitter frame lengths.
        for (int k = 0; k < 40; k++) begin
            busy_len = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus_select_i = 1'b1;
                bus_we_i     = 1'b0;
                @(negedge clk);
                check("rnd_read_noack", 32'(bus_ack_o), 32'd0);
                bus_select_i = 1'b0;
            end else begin
                bus_write(8'($urandom), 400);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            check_flags("rnd");
        end
        busy_len = 10;
        drain(2000);

        // Reset while a frame is in flight and five bytes are queued.
        bus_write(8'hA0, 20);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (tx_busy_i) ok = 1'b1;
        end
        check("inflight_busy", 32'(ok), 32'd1);
        force_busy = 1'b1;
        for (int i = 1; i < 6; i++) bus_write(8'hA0 + 8'(i), 20);
        check("prerst_count", 32'(model_count()), 32'd5);
        check_flags("prerst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_empty", 32'(empty_o),    32'd1);
        check("mid_rst_full",  32'(full_o),     32'd0);
        check("mid_rst_start", 32'(tx_start_o), 32'd0);
        check("mid_rst_ack",   32'(bus_ack_o),  32'd0);
        check("mid_rst_data",  32'(tx_data_o),  32'd0);
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus_write(8'hB0, 20);
        bus_write(8'hB1, 20);
        n = got_q.size();
        repeat (20) @(negedge clk);
        check("rst_nostart", 32'(got_q.size() - n), 32'd0);
        force_busy = 1'b0;
        drain(500);

        check("final_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("order_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check_flags("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
